// File: rtl/spart_driver.sv
// spart_driver -- bus-master stand-in for the processor in front of the mini SPART.
//
// After reset it programs the baud-rate generator divisor (selected by the
// br_cfg switches) with two single-cycle writes, then loops: wait for a
// received byte, read it, wait for the transmitter, write it back.
// A change on br_cfg is picked up the next time the loop passes through IDLE.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   br_cfg     baud select switches (asynchronous, synchronized here)
//   rda        SPART receive data available
//   tbr        SPART transmit buffer ready
//   iocs       chip select (registered)
//   iorw       1 = read from SPART, 0 = write to SPART (registered)
//   ioaddr     00 data, 01 status, 10 DB low, 11 DB high (registered)
//   databus    shared bus, driven only on write cycles
//   last_char  most recent byte echoed
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'd1301,
    parameter logic [15:0] DIV_9600  = 16'd650,
    parameter logic [15:0] DIV_19200 = 16'd325,
    parameter logic [15:0] DIV_38400 = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_char
);

    // ST_RST is only occupied while rst is high; it makes CFG_LO appear on
    // the first edge after rst falls.
    localparam logic [2:0] ST_RST   = 3'd0;
    localparam logic [2:0] CFG_LO   = 3'd1;
    localparam logic [2:0] CFG_HI   = 3'd2;
    localparam logic [2:0] IDLE     = 3'd3;
    localparam logic [2:0] READ     = 3'd4;
    localparam logic [2:0] WAIT_TBR = 3'd5;
    localparam logic [2:0] WRITE    = 3'd6;
    localparam logic [2:0] GUARD    = 3'd7;

    logic [2:0] state_q, state_d;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] cfg_q, cfg_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic [7:0] last_char_q, last_char_d;
    logic       iocs_q, iocs_d;
    logic       iorw_q, iorw_d;
    logic [1:0] ioaddr_q, ioaddr_d;
    logic [7:0] dout_q, dout_d;
    logic       drv_q, drv_d;

    function automatic logic [7:0] div_byte(input logic [1:0] cfg, input logic hi);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            default: d = DIV_38400;
        endcase
        return hi ? d[15:8] : d[7:0];
    endfunction

    // Two-flop synchronizer; deliberately not reset so it keeps tracking the
    // switches while rst is held and is settled when CFG_LO samples it.
    always_ff @(posedge clk) begin
        sync1_q <= br_cfg;
        sync2_q <= sync1_q;
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        rx_byte_d   = rx_byte_q;
        last_char_d = last_char_q;
        case (state_q)
            ST_RST:   state_d = CFG_LO;
            CFG_LO:   state_d = CFG_HI;
            CFG_HI:   state_d = IDLE;
            IDLE: begin
                if (sync2_q != cfg_q) state_d = CFG_LO;
                else if (rda)         state_d = READ;
            end
            READ: begin
                rx_byte_d = databus;  // SPART drives the data register this cycle
                state_d   = WAIT_TBR;
            end
            WAIT_TBR: if (tbr) state_d = WRITE;
            WRITE:    state_d = GUARD;
            GUARD:    state_d = IDLE;
            default:  state_d = ST_RST;
        endcase

        // Bus outputs are decoded from the next state and registered, so each
        // state's bus cycle lines up with the cycle that state is occupied.
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b01;
        drv_d    = 1'b0;
        dout_d   = 8'h00;
        case (state_d)
            CFG_LO: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b10;
                drv_d    = 1'b1;
                dout_d   = div_byte(sync2_q, 1'b0);
                cfg_d    = sync2_q;
            end
            CFG_HI: begin
                // cfg_q was loaded on entry to CFG_LO, so both halves match.
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b11;
                drv_d    = 1'b1;
                dout_d   = div_byte(cfg_q, 1'b1);
            end
            READ: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b1;
                ioaddr_d = 2'b00;
            end
            WRITE: begin
                iocs_d      = 1'b1;
                iorw_d      = 1'b0;
                ioaddr_d    = 2'b00;
                drv_d       = 1'b1;
                dout_d      = rx_byte_q;
                last_char_d = rx_byte_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST;
            cfg_q       <= 2'b00;
            rx_byte_q   <= 8'h00;
            last_char_q <= 8'h00;
            iocs_q      <= 1'b0;
            iorw_q      <= 1'b1;
            ioaddr_q    <= 2'b01;
            dout_q      <= 8'h00;
            drv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            rx_byte_q   <= rx_byte_d;
            last_char_q <= last_char_d;
            iocs_q      <= iocs_d;
            iorw_q      <= iorw_d;
            ioaddr_q    <= ioaddr_d;
            dout_q      <= dout_d;
            drv_q       <= drv_d;
        end
    end

    assign iocs      = iocs_q;
    assign iorw      = iorw_q;
    assign ioaddr    = ioaddr_q;
    assign last_char = last_char_q;
    assign databus   = drv_q ? dout_q : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] last_char;
    logic [7:0] rx_data = 8'h00;
    wire  [7:0] databus;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_t;
    bus_t sb[$];

    always #5 clk = ~clk;

    // SPART model side of the bus: supplies rx_data on data reads, and holds a
    // keeper pattern (C3) whenever the driver must be off the bus, so any
    // stray drive from the DUT shows up as a corrupted value.
    wire       tb_drv = !(iocs && !iorw);
    wire [7:0] tb_val = (iocs && iorw && ioaddr == 2'b00) ? rx_data : 8'hC3;
    assign databus = tb_drv ? tb_val : 8'hzz;

    spart_driver dut (
        .clk       (clk),
        .rst       (rst),
        .br_cfg    (br_cfg),
        .rda       (rda),
        .tbr       (tbr),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .last_char (last_char)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected transaction for every chip-select cycle.
    logic       prev_iocs = 1'b0;
    logic [2:0] prev_op = 3'b000;
    always @(negedge clk) begin
        bus_t got;
        if (mon_en) begin
            if (tb_drv) chk("bus_release", {8'h00, databus}, {8'h00, tb_val});
            if (iocs) begin
                got = {iorw, ioaddr, databus};
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: got rw=%b addr=%b data=%h, expected none",
                             iorw, ioaddr, databus);
                end else begin
                    chk("bus_cycle", {5'b0, got}, {5'b0, sb.pop_front()});
                end
                if (prev_iocs) begin
                    tests++;
                    if ({iorw, ioaddr} == prev_op) begin
                        fails++;
                        $display("FAIL access_len: rw/addr %b held for 2 cycles, expected 1", prev_op);
                    end
                end
            end
            prev_iocs = iocs;
            prev_op   = {iorw, ioaddr};
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic rw, input logic [1:0] a, input logic [7:0] d);
        sb.push_back({rw, a, d});
    endtask

    task automatic push_cfg(input logic [15:0] div);
        push(1'b0, 2'b10, div[7:0]);
        push(1'b0, 2'b11, div[15:8]);
    endtask

    task automatic wait_read();
        int n = 0;
        while (!(iocs && iorw && ioaddr == 2'b00) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL read_timeout: no READ in %0d cycles, expected one", n);
        end
    endtask

    // Present a received byte; called at posedge+2 with the driver in IDLE
    // when chk_lat is set. Returns at the negedge of the READ cycle.
    task automatic send(input logic [7:0] b, input bit chk_lat, input bit push_wr);
        rx_data = b;
        rda     = 1'b1;
        push(1'b1, 2'b00, b);
        if (push_wr) push(1'b0, 2'b00, b);
        if (chk_lat) begin
            @(posedge clk);
            @(negedge clk);
            chk("rd_latency", {12'h0, iocs, iorw, ioaddr}, 16'h000C);
        end
        wait_read();
        rda = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        cyc(4);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_bus", {12'h0, iocs, iorw, ioaddr}, 16'h0005);
        chk("rst_last_char", {8'h0, last_char}, 16'h0000);

        // 1: divisor for 9600 = 0x028A, CFG_LO one cycle after rst falls
        push_cfg(16'h028A);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("cfg_lo_lat", {12'h0, iocs, iorw, ioaddr}, 16'h000A);
        @(negedge clk);
        chk("cfg_hi", {12'h0, iocs, iorw, ioaddr}, 16'h000B);
        @(negedge clk);
        chk("cfg_idle", {12'h0, iocs, iorw, ioaddr}, 16'h0005);

        // 2: echo with transmitter ready
        tbr = 1'b1;
        cyc(2);
        send(8'h41, 1'b1, 1'b1);
        cyc(6);
        chk("echo_41", {8'h0, last_char}, 16'h0041);

        // 3: transmitter busy for 20 cycles, then exactly one write
        tbr = 1'b0;
        send(8'h5A, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("wait_idle", {12'h0, iocs, iorw, ioaddr}, 16'h0005);
        push(1'b0, 2'b00, 8'h5A);
        @(posedge clk); #2 tbr = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wr_latency", {12'h0, iocs, iorw, ioaddr}, 16'h0008);
        cyc(4);
        chk("echo_5a", {8'h0, last_char}, 16'h005A);

        // 4: br_cfg 01->11 during WAIT_TBR; echo completes before reprogram
        tbr = 1'b0;
        cyc(2);
        send(8'h77, 1'b1, 1'b0);
        cyc(2);
        br_cfg = 2'b11;
        cyc(6);
        push(1'b0, 2'b00, 8'h77);
        push_cfg(16'h00A2);
        tbr = 1'b1;
        cyc(12);
        chk("echo_77", {8'h0, last_char}, 16'h0077);
        chk("sb_empty_t4", sb.size(), 16'h0000);

        // 5: reset during WAIT_TBR discards the pending byte
        rst = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("rst2_last_char", {8'h0, last_char}, 16'h0000);
        push_cfg(16'h00A2);
        @(posedge clk); #2 rst = 1'b0;
        cyc(5);
        tbr = 1'b0;
        send(8'h99, 1'b1, 1'b0);
        cyc(3);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_bus", {12'h0, iocs, iorw, ioaddr}, 16'h0005);
        chk("rst_mid_last_char", {8'h0, last_char}, 16'h0000);
        tbr = 1'b1;
        push_cfg(16'h00A2);
        @(posedge clk); #2 rst = 1'b0;
        cyc(10);
        chk("no_stale_write", {8'h0, last_char}, 16'h0000);
        chk("sb_empty_t5", sb.size(), 16'h0000);

        // 4800 baud divisor 1301 = 0x0515
        push_cfg(16'h0515);
        br_cfg = 2'b00;
        cyc(10);
        chk("sb_empty_cfg00", sb.size(), 16'h0000);

        // byte arriving during reconfiguration (19200 -> 0x0145) is serviced
        push_cfg(16'h0145);
        br_cfg = 2'b10;
        n = 0;
        while (!(iocs && ioaddr == 2'b10) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cfg10_seen", {15'h0, n >= 50}, 16'h0000);
        rx_data = 8'h3C;
        rda = 1'b1;
        push(1'b1, 2'b00, 8'h3C);
        push(1'b0, 2'b00, 8'h3C);
        wait_read();
        rda = 1'b0;
        cyc(8);
        chk("echo_3c", {8'h0, last_char}, 16'h003C);
        chk("sb_empty_end", sb.size(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
